// File: rtl/dev_timer.sv
// Memory-mapped 32-bit countdown timer: CTRL/PRESET/COUNT window with byte-masked writes,
// combinational read-back and a registered interrupt request.
module dev_timer #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state, state_n;
  logic [3:0]  ctrl, ctrl_n;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        pending, pending_n;
  logic        irq_n;

  logic       hit;
  logic [1:0] offset;
  logic       wr_ctrl;
  logic       wr_preset;

  assign hit       = (addr[31:4] == BASE[31:4]);
  assign offset    = addr[3:2];
  assign wr_ctrl   = hit && (|byteen) && (offset == 2'd0);
  assign wr_preset = hit && (|byteen) && (offset == 2'd1);

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (offset)
        2'd0:    rdata = {28'b0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = '0;
      endcase
    end
  end

  // FSM effects are computed first; bus writes are applied on top so they take priority.
  always_comb begin
    state_n   = state;
    ctrl_n    = ctrl;
    preset_n  = preset;
    count_n   = count;
    pending_n = pending;

    case (state)
      IDLE: begin
        if (ctrl[0]) state_n = LOAD;
      end
      LOAD: begin
        count_n = preset;
        state_n = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n   = '0;
          pending_n = 1'b1;
          state_n   = INT;
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'b00) begin
          state_n   = IDLE;
          ctrl_n[0] = 1'b0;
        end else begin
          state_n   = LOAD;
          pending_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (wr_ctrl) begin
      if (byteen[0]) ctrl_n = wdata[3:0];
      pending_n = 1'b0;
    end

    if (wr_preset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteen[i]) preset_n[8*i +: 8] = wdata[8*i +: 8];
      end
      pending_n = 1'b0;
    end

    irq_n = pending_n && ctrl_n[3];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      ctrl    <= ctrl_n;
      preset  <= preset_n;
      count   <= count_n;
      pending <= pending_n;
      irq     <= irq_n;
    end
  end

endmodule

// File: tb/tb_dev_timer.sv
// Self-checking bench for dev_timer: directed scenarios with fixed expectations plus
// randomized bus traffic checked against a behavioural model.
module tb_dev_timer;

  localparam logic [31:0] BASE = 32'h0000_7f00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  dev_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = stopped, 1 = reload pending, 2 = counting, 3 = expired.
  int          m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_pend;
  bit          m_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_phase  = 0;
    m_ctrl   = 4'h0;
    m_preset = 32'h0;
    m_count  = 32'h0;
    m_pend   = 0;
    m_irq    = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bit          hit;
    int          off;
    bit          en;
    int          mode;
    logic [31:0] old_preset;
    hit        = (a[31:4] == BASE[31:4]);
    off        = int'(a[3:2]);
    en         = m_ctrl[0];
    mode       = int'(m_ctrl[2:1]);
    old_preset = m_preset;
    if (m_phase == 0) begin
      if (en) m_phase = 1;
    end else if (m_phase == 1) begin
      m_count = old_preset;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (!en) m_phase = 0;
      else if (m_count > 1) m_count = m_count - 1;
      else begin
        m_count = 0;
        m_pend  = 1;
        m_phase = 3;
      end
    end else begin
      if (mode == 0) begin
        m_phase   = 0;
        m_ctrl[0] = 1'b0;
      end else begin
        m_phase = 1;
        m_pend  = 0;
      end
    end
    if (hit && be != 4'b0000) begin
      if (off == 0) begin
        if (be[0]) m_ctrl = wd[3:0];
        m_pend = 0;
      end else if (off == 1) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_preset[8*i +: 8] = wd[8*i +: 8];
        m_pend = 0;
      end
    end
    m_irq = m_pend && m_ctrl[3];
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr   = a;
    byteen = 4'b0000;
    #1;
    d = rdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    rd(BASE + 32'h0, d); check({tag, ".ctrl"},   d, {28'b0, m_ctrl});
    rd(BASE + 32'h4, d); check({tag, ".preset"}, d, m_preset);
    rd(BASE + 32'h8, d); check({tag, ".count"},  d, m_count);
    check({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  // Drive one bus cycle, let one rising edge take it, then compare against the model.
  task automatic step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    addr   = a;
    byteen = be;
    wdata  = wd;
    @(posedge clk);
    model_edge(a, be, wd);
    #1;
    byteen = 4'b0000;
    check_all("model");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(BASE, 4'b0000, 32'h0);
  endtask

  task automatic do_reset();
    logic [31:0] d;
    reset  = 1'b0;
    byteen = 4'b0000;
    repeat (3) @(posedge clk);
    model_clear();
    #1;
    rd(BASE + 32'h0, d); check("rst.ctrl",   d, 32'h0);
    rd(BASE + 32'h4, d); check("rst.preset", d, 32'h0);
    rd(BASE + 32'h8, d); check("rst.count",  d, 32'h0);
    check("rst.irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_cnt [8];
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;

    reset  = 1'b0;
    addr   = BASE;
    byteen = 4'b0000;
    wdata  = 32'h0;
    model_clear();

    // Reset state
    do_reset();

    // One-shot: PRESET=5, CTRL=EN|IM at E0
    step(BASE + 32'h4, 4'b1111, 32'd5);
    step(BASE + 32'h0, 4'b1111, 32'h9);
    exp_cnt = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    for (int k = 1; k <= 8; k++) begin
      step(BASE, 4'b0000, 32'h0);
      rd(BASE + 32'h8, d);
      check($sformatf("oneshot.count.E%0d", k), d, exp_cnt[k-1]);
      check($sformatf("oneshot.irq.E%0d", k), {31'b0, irq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    rd(BASE + 32'h0, d); check("oneshot.ctrl_after", d, 32'h8);
    idle(3);
    check("oneshot.irq_held", {31'b0, irq}, 32'd1);
    step(BASE + 32'h0, 4'b0001, 32'h0);
    check("oneshot.irq_cleared", {31'b0, irq}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=EN|MODE=01|IM
    do_reset();
    step(BASE + 32'h4, 4'b1111, 32'd3);
    step(BASE + 32'h0, 4'b1111, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      step(BASE, 4'b0000, 32'h0);
      check($sformatf("auto.irq.E%0d", k), {31'b0, irq},
            (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
      if (k == 7) begin
        rd(BASE + 32'h8, d);
        check("auto.reload_count", d, 32'd3);
      end
    end

    // Byte lanes and read-only COUNT
    do_reset();
    step(BASE + 32'h4, 4'b0100, 32'h00AB_0000);
    rd(BASE + 32'h4, d); check("lane.preset", d, 32'h00AB_0000);
    step(BASE + 32'h4, 4'b0001, 32'hFFFF_FF12);
    rd(BASE + 32'h4, d); check("lane.preset2", d, 32'h00AB_0012);
    step(BASE + 32'h8, 4'b1111, 32'hFFFF_FFFF);
    rd(BASE + 32'h8, d); check("lane.count_ro", d, 32'h0);
    step(BASE + 32'h0, 4'b1111, 32'hFFFF_FFF0);
    rd(BASE + 32'h0, d); check("lane.ctrl_upper", d, 32'h0);

    // Masked expiry and out-of-window access
    do_reset();
    step(BASE + 32'h4, 4'b1111, 32'd2);
    step(BASE + 32'h0, 4'b1111, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(BASE, 4'b0000, 32'h0);
      check($sformatf("masked.irq.E%0d", k), {31'b0, irq}, 32'd0);
    end
    rd(BASE + 32'h0, d); check("masked.en_cleared", d, 32'h0);
    step(BASE + 32'h10, 4'b1111, 32'hFFFF_FFFF);
    rd(BASE + 32'h10, d); check("miss.rdata", d, 32'h0);
    rd(BASE + 32'h4, d);  check("miss.preset", d, 32'd2);
    rd(BASE + 32'h0, d);  check("miss.ctrl", d, 32'h0);

    // Mid-count disable, then asynchronous reset
    do_reset();
    step(BASE + 32'h4, 4'b1111, 32'd10);
    step(BASE + 32'h0, 4'b1111, 32'h1);
    idle(5);
    rd(BASE + 32'h8, d); check("dis.count7", d, 32'd7);
    step(BASE + 32'h0, 4'b0001, 32'h0);
    rd(BASE + 32'h8, d); check("dis.count6", d, 32'd6);
    idle(3);
    rd(BASE + 32'h8, d); check("dis.frozen", d, 32'd6);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    addr = BASE + 32'h8; #0.5; check("arst.count",  rdata, 32'h0);
    addr = BASE + 32'h4; #0.5; check("arst.preset", rdata, 32'h0);
    check("arst.irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 30) begin
        case ($urandom_range(0, 4))
          0: a = BASE + 32'h0;
          1: a = BASE + 32'h4;
          2: a = BASE + 32'h8;
          3: a = BASE + 32'hC;
          default: a = BASE + 32'h10 + ($urandom_range(0, 3) << 2);
        endcase
        be = 4'($urandom_range(0, 15));
        wd = $urandom;
        if (a == BASE + 32'h4 && $urandom_range(0, 3) != 0) wd = wd & 32'h0000_000F;
        step(a, be, wd);
      end else begin
        step(BASE + ($urandom_range(0, 3) << 2), 4'b0000, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
